// File: rtl/mux_rr_arbiter.sv
// Round-robin 8-way arbiter producing a registered one-hot grant and binary mux select.
// Optional hold limit with timeout pulse: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] s_reg, s_next;
  logic [7:0] gnt_reg, gnt_next;
  logic       timeout_reg, timeout_next;
  logic       new_grant;
  logic       hold_expire;
  logic       release_now;
  logic [3:0] pick;

  // Searches ptr+1 .. ptr+8 (mod 8); the last candidate is ptr itself, which
  // gives the re-grant of a sole remaining requester for free.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick = rr_pick(req, ptr_reg);

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_reg;

  assign hold_expire = (state_reg == GRANT) && (hold_reg == 8'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 8'd0;
    end else if (new_grant) begin
      hold_reg <= 8'd0;
    end else if (state_reg == GRANT) begin
      hold_reg <= hold_reg + 8'd1;
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

  assign release_now = done || !req[s_reg] || hold_expire;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    s_next       = s_reg;
    gnt_next     = gnt_reg;
    timeout_next = 1'b0;
    new_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick[3]) new_grant = 1'b1;
      end
      GRANT: begin
        if (release_now) begin
          // Only flag the hold limit when it is the sole reason for release.
          timeout_next = hold_expire && !done && req[s_reg];
          if (pick[3]) begin
            new_grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = 8'h00;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
      end
    endcase
    if (new_grant) begin
      state_next = GRANT;
      s_next     = pick[2:0];
      ptr_next   = pick[2:0];
      gnt_next   = 8'd1 << pick[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd7;
      s_reg       <= 3'd0;
      gnt_reg     <= 8'h00;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      s_reg       <= s_next;
      gnt_reg     <= gnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign s       = s_reg;
  assign gnt     = gnt_reg;
  assign busy    = (state_reg == GRANT);
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus pushes expected outputs, a monitor pops and compares.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] s;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   fails;
  int   txn;

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .s(s), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d: req=%02h done=%0b -> gnt=%02h s=%0d busy=%0b timeout=%0b (exp %02h/%0d/%0b/%0b)",
               txn, req, done, gnt, s, busy, timeout, e.gnt, e.s, e.busy, e.timeout);
      check("gnt", int'(gnt), int'(e.gnt));
      check("s", int'(s), int'(e.s));
      check("busy", int'(busy), int'(e.busy));
      check("timeout", int'(timeout), int'(e.timeout));
    end
  end

  // Apply inputs for one cycle and queue the outputs expected after that edge.
  task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                      input logic [2:0] es, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.gnt = eg; e.s = es; e.busy = eb; e.timeout = et;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 8'h00;
    done  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nx;
    logic [2:0] ts;
    checks = 0;
    fails  = 0;
    txn    = 0;
    req    = 8'h00;
    done   = 1'b0;
    rst_n  = 1'b0;
    #12;
    check("reset_gnt", int'(gnt), 0);
    check("reset_s", int'(s), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: grant, re-grant on done, then idle when req drops.
    step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // All requesting, done every 3 cycles: 0,1,...,7,0 back to back.
    do_reset();
    step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      nx = (i + 1) % 8;
      step(8'hFF, 1'b0, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      step(8'hFF, 1'b0, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      step(8'hFF, 1'b1, 8'(1 << nx), 3'(nx), 1'b1, 1'b0);
    end

    // Owner 0 drops, 7 takes over; then done with req=81 wraps to 0.
    step(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    step(8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    // Move to owner 3, hold, then req[3] drops with 5 waiting.
    step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    // Everything drops: idle with s retained.
    step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);

    // req=06 held without done; ptr=5 so 1 wins first.
    for (int n = 1; n <= 10; n++) begin
`ifdef MUX_ARB_TIMEOUT_EN
      ts = (((n - 1) / 4) % 2 == 0) ? 3'd1 : 3'd2;
      step(8'h06, 1'b0, 8'(1 << ts), ts, 1'b1, (n > 1) && ((n - 1) % 4 == 0));
`else
      ts = 3'd1;
      step(8'h06, 1'b0, 8'(1 << ts), ts, 1'b1, 1'b0);
`endif
    end

    // Owner 4, then asynchronous reset mid-cycle.
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_busy", int'(busy), 0);
    check("async_s", int'(s), 0);
    check("async_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
